// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer: steps a 2-input gate under test through its four
// input vectors, samples F after a programmable settle time and scores the
// result against an expected truth table.
module gate_truth_sequencer #(
    parameter logic [3:0]  TRUTH         = 4'b1000,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_f,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] fail_count,
    output logic [1:0] vec_idx
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ST_W  = 2;

    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_SETTLE = 2'd1;
    localparam logic [ST_W-1:0] ST_CHECK  = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    // With no settle time a freshly applied vector goes straight to CHECK.
    localparam logic [ST_W-1:0]  ST_APPLY    = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;

    logic [ST_W-1:0]  state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             gate_a_nxt, gate_b_nxt;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic [3:0]       fail_mask_nxt;
    logic [2:0]       fail_count_nxt;
    logic [1:0]       vec_idx_nxt;
    logic [1:0]       vec_inc;
    logic             mismatch;

    assign vec_inc = vec_idx + 2'd1;
    // Case inequality so an unknown F is scored as a mismatch in simulation.
    assign mismatch = (gate_f !== TRUTH[vec_idx]);

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            fail_count <= '0;
            vec_idx    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            gate_a     <= gate_a_nxt;
            gate_b     <= gate_b_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            fail_mask  <= fail_mask_nxt;
            fail_count <= fail_count_nxt;
            vec_idx    <= vec_idx_nxt;
        end
    end

    // Next-state and next-output logic; abort outranks start in every state.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        gate_a_nxt     = gate_a;
        gate_b_nxt     = gate_b;
        pass_nxt       = pass;
        fail_mask_nxt  = fail_mask;
        fail_count_nxt = fail_count;
        vec_idx_nxt    = vec_idx;

        if (abort) begin
            state_nxt      = ST_IDLE;
            cnt_nxt        = '0;
            gate_a_nxt     = 1'b0;
            gate_b_nxt     = 1'b0;
            pass_nxt       = 1'b0;
            fail_mask_nxt  = '0;
            fail_count_nxt = '0;
            vec_idx_nxt    = '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_nxt      = ST_APPLY;
                        cnt_nxt        = SETTLE_LOAD;
                        gate_a_nxt     = 1'b0;
                        gate_b_nxt     = 1'b0;
                        pass_nxt       = 1'b0;
                        fail_mask_nxt  = '0;
                        fail_count_nxt = '0;
                        vec_idx_nxt    = '0;
                    end
                end
                ST_SETTLE: begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        fail_mask_nxt[vec_idx] = 1'b1;
                        fail_count_nxt         = fail_count + 3'd1;
                    end
                    if (vec_idx != 2'd3) begin
                        state_nxt   = ST_APPLY;
                        cnt_nxt     = SETTLE_LOAD;
                        vec_idx_nxt = vec_inc;
                        gate_a_nxt  = vec_inc[1];
                        gate_b_nxt  = vec_inc[0];
                    end else begin
                        state_nxt = ST_DONE;
                        pass_nxt  = (fail_count_nxt == 3'd0);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_CHECK);
        done_nxt = (state_nxt == ST_DONE);
    end

endmodule
